// File: rtl/sram_controller_if.sv
// CPU-side request/response bundle between the MEM stage and the SRAM controller.
// Combinational ready path, registered read data.
// Requester holds wr_en/rd_en with stable address/data until ready is seen high.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit loads/stores into two sequential 16-bit synchronous SRAM accesses.
// Latency: store 3 cycles + DONE, load 4 cycles + DONE, counted from the request cycle.
// Backpressure: ready held low while an access is in flight, freezing the pipeline.
module sram_controller #(
    parameter int          ADDR_W = 18,
    parameter logic [31:0] BASE   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_CAP,
        DONE
    } state_t;

    state_t              state;
    logic [31:0]         offset;
    logic [ADDR_W-2:0]   idx_in;
    logic [ADDR_W-2:0]   idx_q;
    logic [15:0]         hi_q;
    logic [15:0]         dq_out;
    logic                unused_bits;

    // Byte offset into the SRAM window; the byte lane bits and anything above the
    // window are dropped, so out-of-range addresses simply wrap.
    assign offset      = bus.address - BASE;
    assign idx_in      = offset[ADDR_W:2];
    assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

    // The bus is driven exactly while a write strobe is active; reset forces WE_N
    // high and so releases the bus immediately.
    assign SRAM_DQ = SRAM_WE_N ? 16'bz : dq_out;

    // Idle with no request reports ready so the pipeline never stalls on a no-op.
    assign bus.ready = (state == DONE) ||
                       ((state == IDLE) && !bus.wr_en && !bus.rd_en);

    // Access sequencer: SRAM strobes/address are registered and set up on the
    // edge entering the state in which they are valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            SRAM_WE_N     <= 1'b1;
            SRAM_ADDR     <= '0;
            bus.read_data <= '0;
            idx_q         <= '0;
            hi_q          <= '0;
            dq_out        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        state     <= WR_LO;
                        idx_q     <= idx_in;
                        hi_q      <= bus.write_data[31:16];
                        SRAM_WE_N <= 1'b0;
                        SRAM_ADDR <= {idx_in, 1'b0};
                        dq_out    <= bus.write_data[15:0];
                    end else if (bus.rd_en) begin
                        state     <= RD_LO;
                        idx_q     <= idx_in;
                        SRAM_ADDR <= {idx_in, 1'b0};
                    end
                end
                WR_LO: begin
                    state     <= WR_HI;
                    SRAM_ADDR <= {idx_q, 1'b1};
                    dq_out    <= hi_q;
                end
                WR_HI: begin
                    state     <= DONE;
                    SRAM_WE_N <= 1'b1;
                end
                RD_LO: begin
                    state     <= RD_HI;
                    SRAM_ADDR <= {idx_q, 1'b1};
                end
                RD_HI: begin
                    // Low halfword addressed in RD_LO is on the bus now.
                    state                <= RD_CAP;
                    bus.read_data[15:0]  <= SRAM_DQ;
                end
                RD_CAP: begin
                    state                <= DONE;
                    bus.read_data[31:16] <= SRAM_DQ;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    SRAM_WE_N <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural synchronous SRAM and a
// read-result scoreboard fed from a halfword shadow of the expected SRAM contents.
// Every wait on the DUT is bounded by a cycle budget.
module tb_sram_controller;

    localparam int ADDR_W = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if bus ();
    wire  [15:0]       SRAM_DQ;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_N;

    sram_controller #(.ADDR_W(ADDR_W), .BASE(32'd1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N)
    );

    // Synchronous SRAM: write commits on the edge while WE_N is low, read data
    // appears the cycle after the address. It only drives when the bench allows.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] rd_q;
    logic        sram_oe;
    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
        rd_q <= mem[SRAM_ADDR];
    end
    assign SRAM_DQ = (sram_oe && SRAM_WE_N) ? rd_q : 16'bz;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sh [0:15];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    logic [15:0] zz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure ready-low cycles, check strobes and read result.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input string tag);
        int   lat;
        int   idx;
        logic we_seen;
        logic [31:0] exp_rd;
        idx = int'((a - 32'd1024) >> 2);
        if (w) begin
            sh[2*idx]   = d[15:0];
            sh[2*idx+1] = d[31:16];
        end else if (r) begin
            exp_q.push_back({sh[2*idx+1], sh[2*idx]});
        end
        @(negedge clk);
        bus.wr_en      = w;
        bus.rd_en      = r;
        bus.address    = a;
        bus.write_data = d;
        sram_oe        = r && !w;
        #1;
        lat     = 0;
        we_seen = 1'b0;
        while (!bus.ready && lat < 12) begin
            @(negedge clk);
            #1;
            lat++;
            if (!SRAM_WE_N) we_seen = 1'b1;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_we_strobe"}, {31'd0, we_seen}, {31'd0, w});
        if (r && !w) begin
            exp_rd = exp_q.pop_front();
            check({tag, "_rdata"}, bus.read_data, exp_rd);
            last_rd = exp_rd;
        end else begin
            check({tag, "_rdata_hold"}, bus.read_data, last_rd);
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        sram_oe   = 1'b0;
    endtask

    initial begin
        zz             = 16'bz;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        sram_oe        = 1'b0;
        last_rd        = '0;
        for (int i = 0; i < 16; i++) sh[i] = 16'h0;

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_ready", {31'd0, bus.ready}, 32'd1);
        check("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("idle_dq", {16'd0, SRAM_DQ}, {16'd0, zz});
        check("idle_rdata", bus.read_data, 32'd0);

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 3, "st0");
        check("sram0", {16'd0, mem[0]}, 32'h0000BEEF);
        check("sram1", {16'd0, mem[1]}, 32'h0000DEAD);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 4, "ld0");

        access(1'b1, 1'b0, 32'd1028, 32'h12345678, 3, "st1");
        access(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 3, "st2");
        access(1'b0, 1'b1, 32'd1028, 32'h0, 4, "ld1");
        check("sram2", {16'd0, mem[2]}, 32'h00005678);
        check("sram3", {16'd0, mem[3]}, 32'h00001234);
        access(1'b0, 1'b1, 32'd1031, 32'h0, 4, "ld1_lanes");
        access(1'b0, 1'b1, 32'd1024, 32'h0, 4, "ld2");

        access(1'b1, 1'b1, 32'd1032, 32'h0000FFFF, 3, "prio");
        check("sram4", {16'd0, mem[4]}, 32'h0000FFFF);
        check("sram5", {16'd0, mem[5]}, 32'h00000000);

        access(1'b1, 1'b0, 32'd1036, 32'h99998888, 3, "st_pre");

        // Reset in the middle of the high-halfword write.
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1036;
        bus.write_data = 32'hAAAA5555;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_wr_hi_we_n", {31'd0, SRAM_WE_N}, 32'd0);
        rst = 1'b0;
        #1;
        check("arst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("arst_dq", {16'd0, SRAM_DQ}, {16'd0, zz});
        check("arst_ready_req", {31'd0, bus.ready}, 32'd0);
        bus.wr_en = 1'b0;
        #1;
        check("arst_ready_idle", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sh[6]   = 16'h5555;
        last_rd = '0;
        check("sram6_partial", {16'd0, mem[6]}, 32'h00005555);
        check("sram7_kept", {16'd0, mem[7]}, 32'h00009999);
        check("arst_rdata", bus.read_data, 32'd0);

        access(1'b0, 1'b1, 32'd1036, 32'h0, 4, "ld_after_rst");

        for (int i = 0; i < 8; i++) begin
            check($sformatf("shadow%0d", i), {16'd0, mem[i]}, {16'd0, sh[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
